// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the ALU scheduler and its round-robin arbiter.
package alu_sched_pkg;

  localparam int unsigned DefWidth = 8;
  localparam int unsigned DefFuncW = 3;

  localparam logic [2:0] FUNC_ILLEGAL = 3'b111;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StIssue = 2'd1,
    StWait  = 2'd2,
    StResp  = 2'd3
  } sched_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first set request at or after ptr wins, wrapping.
module rr_arbiter #(
  parameter int unsigned N    = 4,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  int unsigned      cand;
  logic [IDX_W-1:0] cand_idx;

  always_comb begin
    grant    = '0;
    idx      = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = 32'(ptr) + i;
      if (cand >= N) cand = cand - N;
      cand_idx = IDX_W'(cand);
      if (!found && req[cand_idx]) begin
        found           = 1'b1;
        grant[cand_idx] = 1'b1;
        idx             = cand_idx;
      end
    end
  end

endmodule

// File: rtl/alu_scheduler.sv
// Shares one clocked ALU between NUM_REQ requesters with round-robin arbitration,
// one operation in flight, and per-requester result/error responses.
module alu_scheduler
  import alu_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = DefWidth,
  parameter int unsigned FUNC_W  = DefFuncW,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                      in_clock,
  input  logic                      in_reset_n,
  input  logic [NUM_REQ-1:0]        in_req_valid,
  output logic [NUM_REQ-1:0]        out_req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]  in_req_lhs,
  input  logic [NUM_REQ*WIDTH-1:0]  in_req_rhs,
  input  logic [NUM_REQ*FUNC_W-1:0] in_req_function,
  output logic [NUM_REQ-1:0]        out_rsp_valid,
  input  logic [NUM_REQ-1:0]        in_rsp_ready,
  output logic [WIDTH-1:0]          out_rsp_result,
  output logic                      out_rsp_error,
  output logic                      out_alu_valid,
  output logic [WIDTH-1:0]          out_alu_lhs,
  output logic [WIDTH-1:0]          out_alu_rhs,
  output logic [FUNC_W-1:0]         out_alu_function,
  input  logic                      in_alu_valid,
  input  logic [WIDTH-1:0]          in_alu_result
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [FUNC_W-1:0] IllegalFn  = FUNC_W'(FUNC_ILLEGAL);
  localparam logic [7:0]        TimeoutCnt = 8'(TIMEOUT);

  sched_state_e      state_q, state_d;
  logic [IdxW-1:0]   ptr_q, ptr_d;
  logic [IdxW-1:0]   grant_q, grant_d;
  logic [WIDTH-1:0]  lhs_q, lhs_d, rhs_q, rhs_d, result_q, result_d;
  logic [FUNC_W-1:0] fn_q, fn_d;
  logic              error_q, error_d;
  logic [7:0]        cnt_q, cnt_d;

  logic [NUM_REQ-1:0] arb_grant;
  logic [IdxW-1:0]    arb_idx;
  logic               arb_found;
  logic [WIDTH-1:0]   sel_lhs, sel_rhs;
  logic [FUNC_W-1:0]  sel_fn;

  rr_arbiter #(
    .N    (NUM_REQ),
    .IDX_W(IdxW)
  ) u_arb (
    .req  (in_req_valid),
    .ptr  (ptr_q),
    .grant(arb_grant),
    .idx  (arb_idx),
    .found(arb_found)
  );

  assign sel_lhs = in_req_lhs[arb_idx*WIDTH +: WIDTH];
  assign sel_rhs = in_req_rhs[arb_idx*WIDTH +: WIDTH];
  assign sel_fn  = in_req_function[arb_idx*FUNC_W +: FUNC_W];

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    grant_d       = grant_q;
    lhs_d         = lhs_q;
    rhs_d         = rhs_q;
    fn_d          = fn_q;
    result_d      = result_q;
    error_d       = error_q;
    cnt_d         = cnt_q;
    out_req_ready = '0;
    out_rsp_valid = '0;
    out_alu_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Ready is masked during reset so no requester sees a phantom accept.
        if (in_reset_n) out_req_ready = arb_grant;
        if (arb_found) begin
          grant_d = arb_idx;
          lhs_d   = sel_lhs;
          rhs_d   = sel_rhs;
          fn_d    = sel_fn;
          if (sel_fn == IllegalFn) begin
            result_d = '0;
            error_d  = 1'b1;
            state_d  = StResp;
          end else begin
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        out_alu_valid = 1'b1;
        cnt_d         = '0;
        state_d       = StWait;
      end
      StWait: begin
        cnt_d = 8'(cnt_q + 8'd1);
        // A valid result takes priority over a coincident timeout.
        if (in_alu_valid) begin
          result_d = in_alu_result;
          error_d  = 1'b0;
          state_d  = StResp;
        end else if (cnt_q == TimeoutCnt) begin
          result_d = '0;
          error_d  = 1'b1;
          state_d  = StResp;
        end
      end
      StResp: begin
        out_rsp_valid[grant_q] = 1'b1;
        if (in_rsp_ready[grant_q]) begin
          ptr_d   = (32'(grant_q) == NUM_REQ - 1) ? '0 : grant_q + IdxW'(1);
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      grant_q  <= '0;
      lhs_q    <= '0;
      rhs_q    <= '0;
      fn_q     <= '0;
      result_q <= '0;
      error_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      lhs_q    <= lhs_d;
      rhs_q    <= rhs_d;
      fn_q     <= fn_d;
      result_q <= result_d;
      error_q  <= error_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out_alu_lhs      = lhs_q;
  assign out_alu_rhs      = rhs_q;
  assign out_alu_function = fn_q;
  assign out_rsp_result   = (state_q == StResp) ? result_q : '0;
  assign out_rsp_error    = (state_q == StResp) ? error_q : 1'b0;

endmodule

// File: tb/tb_alu_scheduler.sv
// Randomised self-checking bench for alu_scheduler with a 1-cycle ALU model and a
// transaction-level reference for arbitration order, latency and response data.
module tb_alu_scheduler;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int F  = 3;
  localparam int TO = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   rsp_valid;
  logic [N-1:0]   rsp_ready = '0;
  logic [W-1:0]   lhs_a[N];
  logic [W-1:0]   rhs_a[N];
  logic [F-1:0]   fn_a[N];
  logic [N*W-1:0] req_lhs, req_rhs;
  logic [N*F-1:0] req_fn;
  logic [W-1:0]   rsp_result;
  logic           rsp_error;
  logic           alu_valid;
  logic [W-1:0]   alu_lhs, alu_rhs;
  logic [F-1:0]   alu_fn;
  logic           alu_in_valid;
  logic [W-1:0]   alu_in_result;

  logic           alu_mute = 1'b0;
  logic           stray = 1'b0;
  logic           alu_v = 1'b0;
  logic [W-1:0]   alu_r = '0;

  int n_checks = 0;
  int n_fail   = 0;
  int ptr_m    = 0;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_lhs[i*W +: W] = lhs_a[i];
      req_rhs[i*W +: W] = rhs_a[i];
      req_fn[i*F +: F]  = fn_a[i];
    end
  end

  alu_scheduler #(
    .NUM_REQ(N),
    .WIDTH  (W),
    .FUNC_W (F),
    .TIMEOUT(TO)
  ) dut (
    .in_clock        (clk),
    .in_reset_n      (rst_n),
    .in_req_valid    (req_valid),
    .out_req_ready   (req_ready),
    .in_req_lhs      (req_lhs),
    .in_req_rhs      (req_rhs),
    .in_req_function (req_fn),
    .out_rsp_valid   (rsp_valid),
    .in_rsp_ready    (rsp_ready),
    .out_rsp_result  (rsp_result),
    .out_rsp_error   (rsp_error),
    .out_alu_valid   (alu_valid),
    .out_alu_lhs     (alu_lhs),
    .out_alu_rhs     (alu_rhs),
    .out_alu_function(alu_fn),
    .in_alu_valid    (alu_in_valid),
    .in_alu_result   (alu_in_result)
  );

  function automatic logic [W-1:0] ref_alu(input logic [F-1:0] f, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    case (f)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      3'd5:    return a;
      3'd6:    return b;
      default: return '0;
    endcase
  endfunction

  // Bench ALU: one-cycle latency, optionally silent to provoke timeouts.
  always @(posedge clk) begin
    alu_v <= alu_valid & ~alu_mute;
    alu_r <= ref_alu(alu_fn, alu_lhs, alu_rhs);
  end
  assign alu_in_valid  = alu_v | stray;
  assign alu_in_result = alu_r;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int model_winner(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int w);
    logic [N-1:0] r;
    r = '0;
    if (w >= 0) r[w] = 1'b1;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full transaction from grant to handshake, checked against the reference.
  task automatic do_txn(input int bp, input bit keep, output int w);
    logic [W-1:0] exp_res;
    bit           illegal, exp_err;
    int           exp_lat, lat, alu_cnt;
    logic [N-1:0] busy_rdy;
    #1;
    w = model_winner(req_valid, ptr_m);
    check_eq("grant", req_ready, onehot(w));
    if (w < 0) return;
    illegal = (fn_a[w] == 3'b111);
    exp_err = illegal || alu_mute;
    exp_res = exp_err ? '0 : ref_alu(fn_a[w], lhs_a[w], rhs_a[w]);
    exp_lat = illegal ? 1 : (alu_mute ? TO + 3 : 3);
    step();
    if (!keep) req_valid[w] = 1'b0;
    #1;
    lat      = 1;
    alu_cnt  = 0;
    busy_rdy = '0;
    while (rsp_valid == '0 && lat < 200) begin
      busy_rdy |= req_ready;
      if (alu_valid) begin
        alu_cnt++;
        check_eq("alu_issue_cycle", lat, 1);
        check_eq("alu_ops", {alu_fn, alu_lhs, alu_rhs}, {fn_a[w], lhs_a[w], rhs_a[w]});
      end
      step();
      lat++;
    end
    check_eq("rsp_latency", lat, exp_lat);
    check_eq("alu_issue_count", alu_cnt, illegal ? 0 : 1);
    check_eq("no_grant_busy", busy_rdy, 0);
    check_eq("rsp_valid", rsp_valid, onehot(w));
    check_eq("rsp_result", rsp_result, exp_res);
    check_eq("rsp_error", rsp_error, exp_err);
    rsp_ready = ~onehot(w) & N'($urandom);
    for (int k = 0; k < bp; k++) begin
      step();
      check_eq("bp_hold", {rsp_valid, rsp_error, rsp_result}, {onehot(w), exp_err, exp_res});
      check_eq("bp_no_grant", req_ready, 0);
    end
    rsp_ready[w] = 1'b1;
    step();
    rsp_ready = '0;
    ptr_m = (w + 1) % N;
    check_eq("rsp_drop", rsp_valid, 0);
  endtask

  task automatic rand_payload();
    for (int i = 0; i < N; i++) begin
      lhs_a[i] = W'($urandom);
      rhs_a[i] = W'($urandom);
      fn_a[i]  = F'($urandom_range(0, 6));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w;
    logic [N-1:0] acc;
    rand_payload();
    req_valid = '1;
    #3;
    check_eq("rst_req_ready", req_ready, 0);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_rsp", {rsp_error, rsp_result}, 0);
    check_eq("rst_alu_valid", alu_valid, 0);
    check_eq("rst_alu_ops", {alu_fn, alu_lhs, alu_rhs}, 0);
    req_valid = '0;
    step();
    step();
    rst_n = 1'b1;

    // Fairness: all requesters held valid continuously.
    req_valid = '1;
    for (int i = 0; i < 5; i++) begin
      do_txn(0, 1'b1, w);
      check_eq("fair_order", w, i % N);
    end
    req_valid = '0;

    // Single request 19 + 7.
    lhs_a[0] = 8'd19;
    rhs_a[0] = 8'd7;
    fn_a[0]  = 3'd0;
    req_valid = 4'b0001;
    do_txn(0, 1'b0, w);
    check_eq("single_winner", w, 0);

    // Illegal function on requester 2.
    fn_a[2] = 3'b111;
    req_valid = 4'b0100;
    do_txn(0, 1'b0, w);

    // Timeout with a silent ALU, then a stray ALU valid in IDLE.
    fn_a[0] = 3'd0;
    alu_mute = 1'b1;
    req_valid = 4'b0001;
    do_txn(0, 1'b0, w);
    alu_mute = 1'b0;
    stray = 1'b1;
    step();
    stray = 1'b0;
    acc = '0;
    for (int k = 0; k < 4; k++) begin
      acc |= rsp_valid;
      step();
    end
    check_eq("stray_ignored", acc, 0);

    // Backpressure on requester 1 with others pending; pointer moves only on handshake.
    rand_payload();
    req_valid = 4'b1111;
    do_txn(5, 1'b0, w);
    check_eq("bp_winner", w, 1);
    do_txn(0, 1'b0, w);
    check_eq("bp_next_grant", w, 2);
    req_valid = '0;

    // Reset while waiting on the ALU.
    alu_mute = 1'b1;
    req_valid = 4'b1000;
    #1;
    check_eq("rw_grant", req_ready, onehot(model_winner(req_valid, ptr_m)));
    step();
    step();
    step();
    req_valid = '1;
    rst_n = 1'b0;
    #1;
    check_eq("rw_req_ready", req_ready, 0);
    check_eq("rw_outs", {rsp_valid, rsp_error, rsp_result, alu_valid, alu_fn, alu_lhs, alu_rhs}, 0);
    req_valid = '0;
    step();
    rst_n = 1'b1;
    ptr_m = 0;
    alu_mute = 1'b0;
    stray = 1'b1;
    step();
    stray = 1'b0;
    acc = '0;
    for (int k = 0; k < TO + 4; k++) begin
      acc |= rsp_valid;
      step();
    end
    check_eq("rw_no_rsp", acc, 0);
    req_valid = '1;
    do_txn(0, 1'b0, w);
    check_eq("rw_next_grant", w, 0);
    req_valid = '0;

    // Randomised traffic.
    for (int t = 0; t < 40; t++) begin
      rand_payload();
      if ($urandom_range(0, 4) == 0) fn_a[$urandom_range(0, N - 1)] = 3'b111;
      alu_mute = ($urandom_range(0, 7) == 0);
      req_valid = N'($urandom_range(1, (1 << N) - 1));
      do_txn($urandom_range(0, 3), 1'b0, w);
      req_valid = '0;
    end
    alu_mute = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
